target_generator: RTL
=====================

# target_generator

Target (mole) generator for the keyboard reaction game. It sits between the PS/2 key-number decode and the score/timer stage. It lights up to ten random targets on LED[15:6], ages them on a game tick, and matches decoded key numbers against lit targets. It emits single-cycle hit/miss/wrong pulses, which the score stage consumes in place of its own LED check.

## Interface
- LIFE_TICKS, 3: ticks a target stays lit before expiring (1..15)
- MAX_ACTIVE, 4: maximum simultaneously lit targets (1..10)
- LFSR_SEED, 16'hACE1: LFSR reset value (nonzero)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-cycle game-rate strobe from a clock-enable divider
- game_start  in  1  one-cycle pulse (debounced, one-pulsed start button)
- game_end  in  1  one-cycle pulse from the timer/score stage
- key_valid  in  1  one-cycle strobe: new key press decoded
- key_num  in  4  decoded digit 0..9; 4'hF = non-digit
- led  out  16  target display
- hit  out  1  one-cycle pulse: key matched a lit target
- miss  out  1  one-cycle pulse: at least one target expired this tick
- wrong  out  1  one-cycle pulse: digit key on an unlit slot
- active_cnt  out  4  number of lit targets

## Operation
- States: IDLE (reset), RUN, OVER.
  - IDLE/OVER + game_start -> RUN. On entry, all slots are cleared and active_cnt is 0.
  - RUN + game_end -> OVER. game_end takes priority over game_start in RUN.
- Slot k (k = 0..9) has a lit flag and a life counter of width ceil(log2(LIFE_TICKS+1)).
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1.
  - Shifts every clk in all states: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Candidate slot c = lfsr[3:0] when < 10, otherwise lfsr[3:0]-10.
- On tick in RUN, applied in this order on the same edge:
  1. Each lit slot not being hit this cycle decrements its life counter. A slot whose counter reaches 0 is cleared. miss asserts if any slot was cleared this way.
  2. Spawn: if slot c is unlit after step 1, is not the slot being hit, and (lit count after steps 1 and hit) < MAX_ACTIVE, then c is lit with life = LIFE_TICKS. Otherwise no spawn and no retry.
- On key_valid in RUN with key_num <= 9:
  - Slot lit: the slot is cleared and hit asserts. The hit takes priority over expiry on the same cycle, so no miss is raised for that slot.
  - Slot unlit: wrong asserts.
- Ignored inputs: key_num >= 10, and key_valid outside RUN.
- led output:
  - IDLE: 16'h0000.
  - RUN: led[15-k] = slot k lit; led[5:0] = 0.
  - OVER: 16'hFFFF.
- active_cnt = popcount of the lit flags, registered.

## Timing
- All outputs are registered. Every event at edge N is visible at N+1.
- Reset values: led 0, hit/miss/wrong 0, active_cnt 0, state IDLE, lfsr LFSR_SEED, all slots cleared.
- Key to led-bit-clear and hit pulse: 1 cycle. Tick to spawn/expire and miss: 1 cycle.
- Pulses last exactly 1 cycle. hit and miss can assert in the same cycle.
- rst asserted mid-game returns the block to reset values immediately (asynchronously). Operation resumes from IDLE.
- A game_start in OVER re-enters RUN next cycle with cleared slots. A tick on that same cycle is ignored.

## Configuration
- TARGET_GEN_DOUBLE_SPAWN_EN:
  - Defined: each tick makes a second spawn attempt after the first, using candidate d derived from lfsr[7:4] with the same mapping. The attempt is made only if d != c and the MAX_ACTIVE cap still allows it.
  - Undefined: one spawn attempt per tick.

## Test plan
- Reset: assert rst mid-RUN with 3 targets lit -> led=16'h0000, active_cnt=0, no pulses, state IDLE next cycle.
- Hit: game_start, then one tick -> exactly one bit of led[15:6] set, active_cnt=1. Send key_valid with the matching key_num -> next cycle hit=1 for 1 cycle, that led bit cleared, active_cnt=0.
- Wrong and ignored keys: in RUN with no lit targets, key_num=4 -> wrong=1 for 1 cycle and led unchanged. key_num=4'hF -> no pulse.
- Expiry: LIFE_TICKS=3, one target lit, no keys -> the target clears and miss=1 on the cycle after the 3rd tick following its spawn.
- Cap: MAX_ACTIVE=4, LIFE_TICKS=15, 30 ticks with no keys -> active_cnt never exceeds 4 and reaches 4.
- Priority and OVER: key_valid for a lit slot on the same cycle as its expiring tick -> hit=1, miss=0. Then game_end -> led=16'hFFFF next cycle and keys are ignored.

Source files
------------

// File: rtl/target_generator.sv
// Reaction-game target generator: LFSR-placed targets on led[15:6], aged on tick, matched against key digits.
// Optional build macro TARGET_GEN_DOUBLE_SPAWN_EN adds a second spawn attempt per tick from lfsr[7:4].
module target_generator #(
  parameter int          LIFE_TICKS = 3,
  parameter int          MAX_ACTIVE = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        game_start,
  input  logic        game_end,
  input  logic        key_valid,
  input  logic [3:0]  key_num,
  output logic [15:0] led,
  output logic        hit,
  output logic        miss,
  output logic        wrong,
  output logic [3:0]  active_cnt
);
  localparam int LW = $clog2(LIFE_TICKS + 1);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic          fb;
  logic [9:0]    lit;
  logic [LW-1:0] life [10];

  logic [3:0]    cand_c;
  logic [9:0]    key_mask, c_mask, hit_mask, expire_mask, lit_aged, spawn_mask, lit_new;
  logic [LW-1:0] life_new [10];
  logic [3:0]    cnt_aged;
  logic [15:0]   led_run;

  function automatic logic [3:0] map_slot(input logic [3:0] v);
    return (v < 4'd10) ? v : v - 4'd10;
  endfunction

  function automatic logic [3:0] popcount(input logic [9:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  assign fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign cand_c = map_slot(lfsr[3:0]);

  // One-hot decodes avoid indexing 10-entry vectors with a 4-bit value that can reach 15.
  for (genvar gi = 0; gi < 10; gi++) begin : g_slot
    assign key_mask[gi]    = key_valid && (key_num == 4'(gi));
    assign c_mask[gi]      = (cand_c == 4'(gi));
    assign led_run[15-gi]  = lit_new[gi];
  end
  assign led_run[5:0] = '0;

`ifdef TARGET_GEN_DOUBLE_SPAWN_EN
  logic [3:0] cand_d;
  logic [9:0] d_mask;
  assign cand_d = map_slot(lfsr[7:4]);
  for (genvar gi = 0; gi < 10; gi++) begin : g_dslot
    assign d_mask[gi] = (cand_d == 4'(gi));
  end
`endif

  always_comb begin
    hit_mask    = key_mask & lit;
    expire_mask = '0;
    for (int k = 0; k < 10; k++) begin
      life_new[k] = life[k];
      if (tick && lit[k] && !hit_mask[k]) begin
        life_new[k] = life[k] - LW'(1);
        if (life[k] == LW'(1)) expire_mask[k] = 1'b1;
      end
    end
    lit_aged   = lit & ~hit_mask & ~expire_mask;
    cnt_aged   = popcount(lit_aged);
    spawn_mask = '0;
    if (tick && !(|(c_mask & lit_aged)) && !(|(c_mask & hit_mask)) &&
        (int'(cnt_aged) < MAX_ACTIVE))
      spawn_mask = c_mask;
`ifdef TARGET_GEN_DOUBLE_SPAWN_EN
    if (tick && (cand_d != cand_c) && !(|(d_mask & lit_aged)) && !(|(d_mask & hit_mask)) &&
        (int'(cnt_aged) + int'(|spawn_mask) < MAX_ACTIVE))
      spawn_mask = spawn_mask | d_mask;
`endif
    lit_new = lit_aged | spawn_mask;
    for (int k = 0; k < 10; k++)
      if (spawn_mask[k]) life_new[k] = LW'(LIFE_TICKS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      lit        <= '0;
      for (int i = 0; i < 10; i++) life[i] <= '0;
      led        <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      wrong      <= 1'b0;
      active_cnt <= '0;
    end else begin
      lfsr  <= {lfsr[14:0], fb};
      hit   <= 1'b0;
      miss  <= 1'b0;
      wrong <= 1'b0;
      case (state)
        RUN: begin
          // game_end wins over everything else arriving on the same edge.
          if (game_end) begin
            state <= OVER;
            led   <= 16'hFFFF;
          end else begin
            lit        <= lit_new;
            life       <= life_new;
            hit        <= |hit_mask;
            miss       <= |expire_mask;
            wrong      <= |(key_mask & ~lit);
            active_cnt <= popcount(lit_new);
            led        <= led_run;
          end
        end
        default: begin
          if (game_start) begin
            state      <= RUN;
            lit        <= '0;
            active_cnt <= '0;
            led        <= '0;
          end
        end
      endcase
    end
  end
endmodule
